chip8_loader: RTL
=================

# chip8_loader

Boot-time loader that fills the CHIP-8 byte memory before the CPU runs. On `start` it writes the 80-byte hex font at `FONT_BASE`. It then accepts a program byte stream through a valid/ready handshake and writes it from `PROG_BASE` upward. It drives the memory write port (`write`, `write_idx`, `write_byte`) directly. It reports completion, loaded length and overflow to the top level, which holds the CPU until `done`.

## Interface
- `FONT_BASE`, default 12'h000: address of font byte 0.
- `PROG_BASE`, default 12'h200: address of first program byte.
- `MEM_TOP`, default 12'hFFF: last writable address.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse to begin a load. Ignored while `busy`.
- `in_valid` in 1: program byte present on `in_byte`.
- `in_byte` in 8: program byte.
- `in_last` in 1: qualifies the final byte of the program. Sampled with `in_valid`.
- `in_ready` out 1: loader accepts a byte this cycle.
- `write` out 1: memory write strobe, one byte per cycle.
- `write_idx` out 12: memory write address.
- `write_byte` out 8: memory write data.
- `busy` out 1: high in FONT and PROG states.
- `done` out 1: high in DONE state.
- `overflow` out 1: program exceeded `MEM_TOP`. Valid while `done`.
- `prog_len` out 12: number of program bytes written.

## Operation
- States: IDLE, FONT, PROG, DONE. Reset state is IDLE.
- IDLE: on `start`, go to FONT. Clear `font_cnt`, `prog_len` and `overflow`.
- FONT: each cycle writes font byte `font_cnt` to `FONT_BASE+font_cnt`, then increments `font_cnt` (7 bits).
  - After byte 79, go to PROG. The program address is loaded with `PROG_BASE`.
  - The font table is the standard COSMAC VIP set, glyphs 0–F, 5 bytes each.
  - Glyph 0 is F0 90 90 90 F0. Glyph 1 is 20 60 20 20 70. Glyph F is F0 80 F0 80 80.
- PROG: `in_ready` = 1.
  - Handshake is `in_valid && in_ready`.
  - Each handshake writes `in_byte` to the program address, then increments the address and `prog_len`.
  - A handshake with `in_last` = 1 goes to DONE.
  - A handshake at address `MEM_TOP` with `in_last` = 0 goes to DONE with `overflow` = 1. The address never wraps.
  - A handshake at `MEM_TOP` with `in_last` = 1 goes to DONE with `overflow` = 0.
- DONE: `in_ready` = 0 and no writes occur. `start` returns to FONT and clears `overflow` and `prog_len`.
- `start` in FONT or PROG is ignored.
- Reset mid-load: all state and outputs return to reset values immediately. Memory contents already written are not restored.
- An empty program is not supported. At least one byte with `in_last` is required to leave PROG.

## Timing
- Reset values:
  - `in_ready`, `write`, `busy`, `done`, `overflow` = 0.
  - `write_idx`, `write_byte`, `prog_len` = 0.
- `write`, `write_idx` and `write_byte` are registered. A write appears on the port one cycle after the cycle that generates it: a FONT cycle or a PROG handshake.
  - Memory commits it on the following edge.
- `in_ready`, `busy` and `done` decode directly from the state register. No combinational path from `in_valid` to `in_ready`.
- Start to first font write: `start` sampled at edge N, then `write` = 1 with `write_idx` = `FONT_BASE` in cycle N+1.
- Font writes occupy 80 consecutive cycles, N+1..N+80. `in_ready` rises in cycle N+81.
- Back-to-back handshakes yield back-to-back writes, 1 byte per cycle.
- Final handshake at edge M:
  - The last write is visible in cycle M+1.
  - `done` = 1 and `in_ready` = 0 from cycle M+1.
  - `prog_len` and `overflow` are final in cycle M+1.
- `start` and a handshake cannot coincide, since `start` is only honoured in IDLE and DONE.

## Test plan
- Reset then pulse `start`: 80 writes appear on consecutive cycles.
  - `write_idx` runs 000..04F.
  - Bytes at 000..004 are F0 90 90 90 F0. Bytes at 04B..04F are F0 80 F0 80 80.
  - `in_ready` stays 0 throughout.
- Stream 3 bytes AA, BB, CC with `in_last` on CC and `in_valid` held continuously:
  - Writes land at 200, 201, 202.
  - `done` = 1, `prog_len` = 3, `overflow` = 0.
- Same stream with `in_valid` toggled randomly: identical memory contents and `prog_len`.
  - No write occurs in any cycle without a prior handshake.
- Stream 0xE00 bytes with no `in_last`:
  - The last write goes to FFF. DONE is reached with `overflow` = 1 and `prog_len` = E00.
  - `in_ready` = 0 afterward.
- Assert `rst_n` = 0 mid-FONT at `font_cnt` = 40: all outputs 0 immediately.
  - After release and a new `start`, the font restarts at 000.
- Pulse `start` in PROG: ignored. Pulse `start` in DONE: full reload, with `prog_len` cleared to 0 in the next cycle.

Source files
------------

// File: rtl/chip8_loader.sv
// chip8_loader: boot-time loader for the CHIP-8 byte memory.
//
// When started, it writes the 80-byte COSMAC VIP hex font at FONT_BASE.
// It then accepts a program byte stream through a valid/ready handshake
// and writes the bytes from PROG_BASE upward, stopping at MEM_TOP.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              pulse to begin a load; honoured only in IDLE/DONE
//   in_valid/in_byte   program byte stream
//   in_last            marks the final program byte
//   in_ready           high in PROG
//   write/write_idx/write_byte  registered memory write port
//   busy, done         state decodes (FONT|PROG, DONE)
//   overflow           program ran past MEM_TOP (valid while done)
//   prog_len           number of program bytes written
module chip8_loader #(
    parameter logic [11:0] FONT_BASE = 12'h000,
    parameter logic [11:0] PROG_BASE = 12'h200,
    parameter logic [11:0] MEM_TOP   = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    output logic        write,
    output logic [11:0] write_idx,
    output logic [7:0]  write_byte,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [11:0] prog_len
);

    typedef enum logic [1:0] {S_IDLE, S_FONT, S_PROG, S_DONE} state_e;

    localparam logic [6:0] FONT_LEN = 7'd80;

    // Glyphs 0..F, 5 bytes each, byte 0 first.
    localparam logic [0:79][7:0] FONT_ROM = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
    };

    state_e      state_q, state_d;
    logic [6:0]  font_cnt_q, font_cnt_d;
    logic [11:0] addr_q, addr_d;
    logic [11:0] prog_len_q, prog_len_d;
    logic        overflow_q, overflow_d;
    logic        write_q, write_d;
    logic [11:0] write_idx_q, write_idx_d;
    logic [7:0]  write_byte_q, write_byte_d;

    always_comb begin
        state_d      = state_q;
        font_cnt_d   = font_cnt_q;
        addr_d       = addr_q;
        prog_len_d   = prog_len_q;
        overflow_d   = overflow_q;
        write_d      = 1'b0;
        write_idx_d  = write_idx_q;
        write_byte_d = write_byte_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Font byte 0 is issued in the start cycle itself so the
                    // first write lands on the port the cycle after start;
                    // the counter therefore resumes at byte 1.
                    state_d      = S_FONT;
                    font_cnt_d   = 7'd1;
                    prog_len_d   = '0;
                    overflow_d   = 1'b0;
                    write_d      = 1'b1;
                    write_idx_d  = FONT_BASE;
                    write_byte_d = FONT_ROM[0];
                end
            end
            S_FONT: begin
                if (font_cnt_q == FONT_LEN) begin
                    // All 80 bytes issued: one settling cycle, then PROG.
                    state_d = S_PROG;
                    addr_d  = PROG_BASE;
                end else begin
                    write_d      = 1'b1;
                    write_idx_d  = FONT_BASE + {5'd0, font_cnt_q};
                    write_byte_d = FONT_ROM[font_cnt_q];
                    font_cnt_d   = font_cnt_q + 7'd1;
                end
            end
            S_PROG: begin
                if (in_valid) begin
                    write_d      = 1'b1;
                    write_idx_d  = addr_q;
                    write_byte_d = in_byte;
                    prog_len_d   = prog_len_q + 12'd1;
                    if (in_last) begin
                        state_d = S_DONE;
                    end else if (addr_q == MEM_TOP) begin
                        // Out of memory with more program pending; the
                        // address is not advanced so it never wraps.
                        state_d    = S_DONE;
                        overflow_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 12'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            font_cnt_q   <= '0;
            addr_q       <= '0;
            prog_len_q   <= '0;
            overflow_q   <= 1'b0;
            write_q      <= 1'b0;
            write_idx_q  <= '0;
            write_byte_q <= '0;
        end else begin
            state_q      <= state_d;
            font_cnt_q   <= font_cnt_d;
            addr_q       <= addr_d;
            prog_len_q   <= prog_len_d;
            overflow_q   <= overflow_d;
            write_q      <= write_d;
            write_idx_q  <= write_idx_d;
            write_byte_q <= write_byte_d;
        end
    end

    assign in_ready   = (state_q == S_PROG);
    assign busy       = (state_q == S_FONT) || (state_q == S_PROG);
    assign done       = (state_q == S_DONE);
    assign overflow   = overflow_q;
    assign prog_len   = prog_len_q;
    assign write      = write_q;
    assign write_idx  = write_idx_q;
    assign write_byte = write_byte_q;

endmodule
